// File: rtl/gshare_btb_predictor.sv
// Gshare branch predictor with a direct-mapped tagged BTB: IF-stage lookup, MEM-stage resolve,
// and an init sweep after reset that clears the tables before predictions are offered.
module gshare_btb_predictor #(
  parameter int DATA_WIDTH = 32,
  parameter int PHT_DEPTH  = 1024,
  parameter int HIST_LEN   = 8,
  parameter int BTB_DEPTH  = 64,
  parameter int TAG_W      = 10,
  localparam int IDX_W     = $clog2(PHT_DEPTH),
  localparam int BI_W      = $clog2(BTB_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] pc,
  output logic                  pred_taken,
  output logic [DATA_WIDTH-1:0] pred_target,
  output logic [IDX_W-1:0]      pred_index,
  output logic                  ready,
  input  logic                  upd_valid,
  input  logic [DATA_WIDTH-1:0] upd_pc,
  input  logic [IDX_W-1:0]      upd_index,
  input  logic                  upd_taken,
  input  logic [DATA_WIDTH-1:0] upd_target,
  input  logic                  upd_pred_taken,
  input  logic [DATA_WIDTH-1:0] upd_pred_target,
  output logic                  mispredict,
  output logic [DATA_WIDTH-1:0] redirect_pc,
  output logic [31:0]           branch_cnt,
  output logic [31:0]           mispred_cnt
);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  localparam logic [IDX_W-1:0] PTR_LAST = IDX_W'(PHT_DEPTH - 1);
  localparam logic [IDX_W:0]   BTB_LIM  = (IDX_W + 1)'(BTB_DEPTH);

  state_t                state;
  logic [IDX_W-1:0]      ptr;
  logic [HIST_LEN-1:0]   ghr;
  logic [1:0]            pht [PHT_DEPTH];
  logic [BTB_DEPTH-1:0]  btb_valid;
  logic [TAG_W-1:0]      btb_tag [BTB_DEPTH];
  logic [DATA_WIDTH-1:0] btb_target [BTB_DEPTH];

  logic [BI_W-1:0]       lk_bi;
  logic [TAG_W-1:0]      lk_tag;
  logic [IDX_W-1:0]      ghr_ext;
  logic                  btb_hit;
  logic [BI_W-1:0]       up_bi;
  logic [TAG_W-1:0]      up_tag;
  logic [1:0]            pht_cur;
  logic [1:0]            pht_next;
  logic [HIST_LEN:0]     ghr_shift;

  // Lookup: reads the tables as they stand, so a same-cycle update is only seen next cycle.
  assign lk_bi      = pc[BI_W+1:2];
  assign lk_tag     = pc[BI_W+TAG_W+1:BI_W+2];
  assign ghr_ext    = IDX_W'(ghr);
  assign pred_index = pc[IDX_W+1:2] ^ ghr_ext;
  assign btb_hit    = btb_valid[lk_bi] && (btb_tag[lk_bi] == lk_tag);
  assign pred_taken = ready && btb_hit && pht[pred_index][1];
  assign pred_target = pred_taken ? btb_target[lk_bi] : pc + DATA_WIDTH'(4);

  assign mispredict  = upd_valid && ready &&
                       ((upd_pred_taken != upd_taken) ||
                        (upd_taken && (upd_pred_target != upd_target)));
  assign redirect_pc = upd_taken ? upd_target : upd_pc + DATA_WIDTH'(4);

  assign up_bi     = upd_pc[BI_W+1:2];
  assign up_tag    = upd_pc[BI_W+TAG_W+1:BI_W+2];
  assign pht_cur   = pht[upd_index];
  assign ghr_shift = {ghr, upd_taken};

  always_comb begin
    pht_next = pht_cur;
    if (upd_taken) begin
      if (pht_cur != 2'b11) pht_next = pht_cur + 2'b01;
    end else begin
      if (pht_cur != 2'b00) pht_next = pht_cur - 2'b01;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_INIT;
      ready       <= 1'b0;
      ptr         <= '0;
      ghr         <= '0;
      branch_cnt  <= '0;
      mispred_cnt <= '0;
    end else begin
      case (state)
        ST_INIT: begin
          pht[ptr] <= 2'b01;
          if ({1'b0, ptr} < BTB_LIM) btb_valid[ptr[BI_W-1:0]] <= 1'b0;
          ptr <= ptr + 1'b1;
          if (ptr == PTR_LAST) begin
            state <= ST_RUN;
            ready <= 1'b1;
          end
        end
        ST_RUN: begin
          if (upd_valid) begin
            pht[upd_index] <= pht_next;
            ghr            <= ghr_shift[HIST_LEN-1:0];
            // Only taken branches allocate; a conflicting entry is simply overwritten.
            if (upd_taken) begin
              btb_valid[up_bi]  <= 1'b1;
              btb_tag[up_bi]    <= up_tag;
              btb_target[up_bi] <= upd_target;
            end
            if (branch_cnt != 32'hFFFF_FFFF) branch_cnt <= branch_cnt + 32'd1;
            if (mispredict && (mispred_cnt != 32'hFFFF_FFFF)) mispred_cnt <= mispred_cnt + 32'd1;
          end
        end
        default: state <= ST_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_gshare_btb_predictor.sv
// Directed bench for gshare_btb_predictor, small-table configuration (16-entry PHT, 1-bit history,
// 4-entry BTB) so the init sweep, aliasing and training are short and hand-checkable.
module tb_gshare_btb_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic [3:0]  pred_index;
  logic        ready;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic [3:0]  upd_index;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_pred_taken;
  logic [31:0] upd_pred_target;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic [31:0] branch_cnt;
  logic [31:0] mispred_cnt;

  int n_cmp  = 0;
  int n_fail = 0;

  logic        o_taken;
  logic [31:0] o_target;
  logic [3:0]  o_index;
  logic        o_mis;
  logic [31:0] o_redir;

  gshare_btb_predictor #(
    .DATA_WIDTH(32), .PHT_DEPTH(16), .HIST_LEN(1), .BTB_DEPTH(4), .TAG_W(10)
  ) dut (
    .clk(clk), .rst(rst), .pc(pc),
    .pred_taken(pred_taken), .pred_target(pred_target), .pred_index(pred_index), .ready(ready),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_index(upd_index), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_pred_taken(upd_pred_taken), .upd_pred_target(upd_pred_target),
    .mispredict(mispredict), .redirect_pc(redirect_pc),
    .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver tasks: no checking here, they only drive and capture outputs.
  task automatic lookup(input logic [31:0] p);
    @(negedge clk);
    pc = p;
    #1;
    o_taken  = pred_taken;
    o_target = pred_target;
    o_index  = pred_index;
  endtask

  task automatic resolve(input logic [31:0] p, input logic [3:0] idx, input logic t,
                         input logic [31:0] tgt, input logic pt, input logic [31:0] ptgt);
    @(negedge clk);
    upd_valid = 1'b1; upd_pc = p; upd_index = idx; upd_taken = t;
    upd_target = tgt; upd_pred_taken = pt; upd_pred_target = ptgt;
    #1;
    o_mis   = mispredict;
    o_redir = redirect_pc;
    @(posedge clk);
    #1;
    upd_valid = 1'b0;
  endtask

  task automatic test_reset;
    int n;
    rst = 1'b1; pc = 32'h100; upd_valid = 1'b0; upd_pc = '0; upd_index = '0; upd_taken = 1'b0;
    upd_target = '0; upd_pred_taken = 1'b0; upd_pred_target = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      pc = (i == 3) ? 32'hFFFF_FFFC : 32'h100 + 32'(i * 4);
      upd_valid = (i == 5); upd_pred_taken = 1'b1; upd_taken = 1'b0; upd_pc = 32'h200;
      #1;
      n_cmp++; if (ready !== 1'b0) begin n_fail++; $display("FAIL init_ready[%0d]: got %b want 0", i, ready); end
      n_cmp++; if (pred_taken !== 1'b0) begin n_fail++; $display("FAIL init_taken[%0d]: got %b want 0", i, pred_taken); end
      n_cmp++; if (pred_target !== pc + 32'd4) begin n_fail++; $display("FAIL init_target[%0d]: got %h want %h", i, pred_target, pc + 32'd4); end
      n_cmp++; if (mispredict !== 1'b0) begin n_fail++; $display("FAIL init_mispredict[%0d]: got %b want 0", i, mispredict); end
      @(negedge clk);
    end
    upd_valid = 1'b0; upd_pred_taken = 1'b0;
    #1;
    n_cmp++; if (ready !== 1'b1) begin n_fail++; $display("FAIL ready_after_16: got %b want 1", ready); end
    n_cmp++; if (branch_cnt !== 32'd0) begin n_fail++; $display("FAIL reset_branch_cnt: got %0d want 0", branch_cnt); end
    n_cmp++; if (mispred_cnt !== 32'd0) begin n_fail++; $display("FAIL reset_mispred_cnt: got %0d want 0", mispred_cnt); end
    lookup(32'hFFFF_FFFC);
    n_cmp++; if (o_target !== 32'h0 || o_taken !== 1'b0) begin n_fail++; $display("FAIL wrap_target: got %h/%b want 0/0", o_target, o_taken); end
    n = 0;
  endtask

  task automatic test_training;
    lookup(32'h100);
    n_cmp++; if (o_index !== 4'd0 || o_taken !== 1'b0 || o_target !== 32'h104) begin n_fail++; $display("FAIL train_cold: got %h/%b/%h want 0/0/104", o_index, o_taken, o_target); end
    resolve(32'h100, 4'd0, 1'b1, 32'hF0, 1'b0, 32'h104);
    n_cmp++; if (o_mis !== 1'b1 || o_redir !== 32'hF0) begin n_fail++; $display("FAIL train_r1: got %b/%h want 1/f0", o_mis, o_redir); end
    lookup(32'h100);
    n_cmp++; if (o_index !== 4'd1 || o_taken !== 1'b0 || o_target !== 32'h104) begin n_fail++; $display("FAIL train_l1: got %h/%b/%h want 1/0/104", o_index, o_taken, o_target); end
    resolve(32'h100, 4'd1, 1'b1, 32'hF0, 1'b0, 32'h104);
    n_cmp++; if (o_mis !== 1'b1) begin n_fail++; $display("FAIL train_r2: got %b want 1", o_mis); end
    lookup(32'h100);
    n_cmp++; if (o_index !== 4'd1 || o_taken !== 1'b1 || o_target !== 32'hF0) begin n_fail++; $display("FAIL train_l2: got %h/%b/%h want 1/1/f0", o_index, o_taken, o_target); end
    resolve(32'h100, 4'd1, 1'b1, 32'hF0, 1'b1, 32'hF0);
    n_cmp++; if (o_mis !== 1'b0) begin n_fail++; $display("FAIL train_r3: got %b want 0", o_mis); end
    resolve(32'h100, 4'd1, 1'b1, 32'hF0, 1'b1, 32'hF0);
    resolve(32'h100, 4'd1, 1'b0, 32'hF0, 1'b1, 32'hF0);
    n_cmp++; if (o_mis !== 1'b1 || o_redir !== 32'h104) begin n_fail++; $display("FAIL train_nt: got %b/%h want 1/104", o_mis, o_redir); end
    lookup(32'h100);
    n_cmp++; if (o_index !== 4'd0 || o_taken !== 1'b1 || o_target !== 32'hF0) begin n_fail++; $display("FAIL train_idx0: got %h/%b/%h want 0/1/f0", o_index, o_taken, o_target); end
    resolve(32'h100, 4'd0, 1'b1, 32'hF0, 1'b1, 32'hF0);
    // Entry 1 saturated at 11 then dropped once to 10: still predicts taken.
    lookup(32'h100);
    n_cmp++; if (o_index !== 4'd1 || o_taken !== 1'b1 || o_target !== 32'hF0) begin n_fail++; $display("FAIL train_sat: got %h/%b/%h want 1/1/f0", o_index, o_taken, o_target); end
    @(negedge clk);
    n_cmp++; if (branch_cnt !== 32'd6 || mispred_cnt !== 32'd3) begin n_fail++; $display("FAIL train_cnt: got %0d/%0d want 6/3", branch_cnt, mispred_cnt); end
  endtask

  task automatic test_mispredict;
    resolve(32'h200, 4'd5, 1'b0, 32'h0, 1'b1, 32'h2F0);
    n_cmp++; if (o_mis !== 1'b1 || o_redir !== 32'h204) begin n_fail++; $display("FAIL mis_nt: got %b/%h want 1/204", o_mis, o_redir); end
    resolve(32'h200, 4'd5, 1'b0, 32'h0, 1'b0, 32'h204);
    n_cmp++; if (o_mis !== 1'b0) begin n_fail++; $display("FAIL mis_correct_nt: got %b want 0", o_mis); end
    lookup(32'h200);
    n_cmp++; if (o_taken !== 1'b0 || o_target !== 32'h204) begin n_fail++; $display("FAIL mis_btb_miss: got %b/%h want 0/204", o_taken, o_target); end
    lookup(32'h100);
    n_cmp++; if (o_taken !== 1'b1 || o_target !== 32'hF0) begin n_fail++; $display("FAIL mis_btb_kept: got %b/%h want 1/f0", o_taken, o_target); end
    @(negedge clk);
    n_cmp++; if (branch_cnt !== 32'd8 || mispred_cnt !== 32'd4) begin n_fail++; $display("FAIL mis_cnt: got %0d/%0d want 8/4", branch_cnt, mispred_cnt); end
  endtask

  task automatic test_target_mismatch;
    resolve(32'h304, 4'd6, 1'b1, 32'h340, 1'b1, 32'h300);
    n_cmp++; if (o_mis !== 1'b1 || o_redir !== 32'h340) begin n_fail++; $display("FAIL tgt_mis: got %b/%h want 1/340", o_mis, o_redir); end
    lookup(32'h304);
    n_cmp++; if (o_index !== 4'd0 || o_taken !== 1'b1 || o_target !== 32'h340) begin n_fail++; $display("FAIL tgt_btb: got %h/%b/%h want 0/1/340", o_index, o_taken, o_target); end
    resolve(32'h304, 4'd6, 1'b1, 32'h340, 1'b1, 32'h340);
    n_cmp++; if (o_mis !== 1'b0) begin n_fail++; $display("FAIL tgt_match: got %b want 0", o_mis); end
    @(negedge clk);
    n_cmp++; if (branch_cnt !== 32'd10 || mispred_cnt !== 32'd5) begin n_fail++; $display("FAIL tgt_cnt: got %0d/%0d want 10/5", branch_cnt, mispred_cnt); end
  endtask

  task automatic test_btb_alias;
    resolve(32'h10, 4'd5, 1'b1, 32'h80, 1'b0, 32'h14);
    n_cmp++; if (o_mis !== 1'b1 || o_redir !== 32'h80) begin n_fail++; $display("FAIL alias_r1: got %b/%h want 1/80", o_mis, o_redir); end
    resolve(32'h10, 4'd5, 1'b1, 32'h80, 1'b0, 32'h14);
    lookup(32'h10);
    n_cmp++; if (o_index !== 4'd5 || o_taken !== 1'b1 || o_target !== 32'h80) begin n_fail++; $display("FAIL alias_hit: got %h/%b/%h want 5/1/80", o_index, o_taken, o_target); end
    resolve(32'h20, 4'd7, 1'b1, 32'hA0, 1'b0, 32'h24);
    n_cmp++; if (o_mis !== 1'b1 || o_redir !== 32'hA0) begin n_fail++; $display("FAIL alias_r2: got %b/%h want 1/a0", o_mis, o_redir); end
    lookup(32'h10);
    n_cmp++; if (o_taken !== 1'b0 || o_target !== 32'h14) begin n_fail++; $display("FAIL alias_evict: got %b/%h want 0/14", o_taken, o_target); end
    @(negedge clk);
    n_cmp++; if (branch_cnt !== 32'd13 || mispred_cnt !== 32'd8) begin n_fail++; $display("FAIL alias_cnt: got %0d/%0d want 13/8", branch_cnt, mispred_cnt); end
  endtask

  task automatic test_reset_mid_run;
    int n;
    @(negedge clk);
    rst = 1'b1;
    upd_valid = 1'b1; upd_pc = 32'h100; upd_index = 4'd0; upd_taken = 1'b1;
    upd_target = 32'hF0; upd_pred_taken = 1'b0; upd_pred_target = 32'h104;
    @(negedge clk);
    rst = 1'b0; upd_valid = 1'b0;
    #1;
    n_cmp++; if (ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready: got %b want 0", ready); end
    n_cmp++; if (branch_cnt !== 32'd0 || mispred_cnt !== 32'd0) begin n_fail++; $display("FAIL rst_cnt: got %0d/%0d want 0/0", branch_cnt, mispred_cnt); end
    n = 0;
    while (ready !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    n_cmp++; if (n != 16) begin n_fail++; $display("FAIL rst_sweep_len: got %0d want 16", n); end
    lookup(32'h100);
    n_cmp++; if (o_index !== 4'd0 || o_taken !== 1'b0 || o_target !== 32'h104) begin n_fail++; $display("FAIL rst_cleared: got %h/%b/%h want 0/0/104", o_index, o_taken, o_target); end
    lookup(32'h304);
    n_cmp++; if (o_taken !== 1'b0 || o_target !== 32'h308) begin n_fail++; $display("FAIL rst_btb_clear: got %b/%h want 0/308", o_taken, o_target); end
  endtask

  task automatic test_saturation;
    @(negedge clk);
    force dut.branch_cnt = 32'hFFFF_FFFF;
    resolve(32'h100, 4'd0, 1'b0, 32'h0, 1'b0, 32'h104);
    n_cmp++; if (o_mis !== 1'b0) begin n_fail++; $display("FAIL sat_mis: got %b want 0", o_mis); end
    @(negedge clk);
    release dut.branch_cnt;
    #1;
    n_cmp++; if (branch_cnt !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL sat_hold: got %h want ffffffff", branch_cnt); end
    resolve(32'h100, 4'd0, 1'b0, 32'h0, 1'b1, 32'hF0);
    @(negedge clk);
    n_cmp++; if (branch_cnt !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL sat_again: got %h want ffffffff", branch_cnt); end
    n_cmp++; if (mispred_cnt !== 32'd1) begin n_fail++; $display("FAIL sat_mispred_cnt: got %0d want 1", mispred_cnt); end
  endtask

  initial begin
    test_reset();
    test_training();
    test_mispredict();
    test_target_mismatch();
    test_btb_alias();
    test_reset_mid_run();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
